// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential / branch / jump / register next-PC select and a misaligned-jr trap.
// Latency: pc loads the selected target on the next rising edge; pc4 and taken are combinational from the current pc.
// Backpressure: stall=1 freezes pc, inst_cnt, addr_err and state; a misaligned jr parks the unit in HALT until reset.
module pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_cond,
  input  logic [31:0] ext_off,
  input  logic [25:0] instr_index,
  input  logic [31:0] rs_val,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        taken,
  output logic        addr_err,
  output logic [31:0] inst_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] OP_SEQ = 2'b00;
  localparam logic [1:0] OP_BR  = 2'b01;
  localparam logic [1:0] OP_J   = 2'b10;
  localparam logic [1:0] OP_JR  = 2'b11;

  state_t      state;
  logic [31:0] target;
  logic        misalign;
  logic        live;

  // Link value and base for every non-register target; wraps naturally at 2^32.
  always_comb begin
    pc4 = pc + 32'd4;
  end

  // Next-PC select; branch and jump targets are word-aligned by construction so only jr is checked.
  always_comb begin
    target = pc4;
    case (npc_op)
      OP_SEQ:  target = pc4;
      OP_BR:   target = br_cond ? (pc4 + ext_off) : pc4;
      OP_J:    target = {pc4[31:28], instr_index, 2'b00};
      OP_JR:   target = rs_val;
      default: target = pc4;
    endcase
  end

  // A request only counts when running, unstalled and not being reset; misalignment is a jr-only fault.
  always_comb begin
    live     = (state == RUN) && !stall && !reset;
    misalign = (npc_op == OP_JR) && (rs_val[1:0] != 2'b00);
    taken    = live && !misalign &&
               ((npc_op == OP_J) || (npc_op == OP_JR) || ((npc_op == OP_BR) && br_cond));
  end

  // State machine and all registered outputs; reset overrides stall, HALT and any select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      inst_cnt <= 32'd0;
      addr_err <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!stall) begin
            if (misalign) begin
              addr_err <= 1'b1;
              state    <= HALT;
            end else begin
              pc       <= target;
              inst_cnt <= inst_cnt + 32'd1;
            end
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: randomized and directed stimulus for pc_unit against a rule-level reference model.
// Latency: expectations are queued when inputs are applied and consumed on the following falling edge.
// Backpressure: none; one expectation is produced and consumed per clock cycle.
module tb_pc_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br_cond;
  logic [31:0] ext_off;
  logic [25:0] instr_index;
  logic [31:0] rs_val;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        taken;
  logic        addr_err;
  logic [31:0] inst_cnt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        taken;
    logic        addr_err;
    logic [31:0] inst_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: what the unit should hold after the last edge.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_err;
  logic        m_halt;

  pc_unit #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .npc_op      (npc_op),
    .br_cond     (br_cond),
    .ext_off     (ext_off),
    .instr_index (instr_index),
    .rs_val      (rs_val),
    .pc          (pc),
    .pc4         (pc4),
    .taken       (taken),
    .addr_err    (addr_err),
    .inst_cnt    (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("pc",       pc,               e.pc);
      cmp("pc4",      pc4,              e.pc4);
      cmp("taken",    {31'd0, taken},   {31'd0, e.taken});
      cmp("addr_err", {31'd0, addr_err}, {31'd0, e.addr_err});
      cmp("inst_cnt", inst_cnt,         e.inst_cnt);
    end
  end

  // Apply one cycle of inputs (called just after a rising edge), queue the expected
  // outputs for this cycle, advance the model across the next edge, then wait for it.
  task automatic step(input logic rst, input logic stl, input logic [1:0] op, input logic br,
                      input logic [31:0] off, input logic [25:0] idx, input logic [31:0] rs);
    exp_t        e;
    logic [31:0] seq;
    logic [31:0] tgt;
    logic        bad;
    reset = rst; stall = stl; npc_op = op; br_cond = br;
    ext_off = off; instr_index = idx; rs_val = rs;

    seq = m_pc + 32'd4;
    bad = (op == 2'd3) && (rs % 4 != 0);
    if (op == 2'd0)                 tgt = seq;
    else if (op == 2'd1 && br)      tgt = seq + off;
    else if (op == 2'd1)            tgt = seq;
    else if (op == 2'd2)            tgt = (seq & 32'hF000_0000) | ({6'd0, idx} * 4);
    else                            tgt = rs;

    e.pc       = m_pc;
    e.pc4      = seq;
    e.addr_err = m_err;
    e.inst_cnt = m_cnt;
    e.taken    = !rst && !m_halt && !stl && !bad && (op == 2'd2 || op == 2'd3 || (op == 2'd1 && br));
    exp_q.push_back(e);

    if (rst) begin
      m_pc = RESET_PC; m_cnt = 0; m_err = 0; m_halt = 0;
    end else if (!m_halt && !stl) begin
      if (bad) begin
        m_err = 1; m_halt = 1;
      end else begin
        m_pc  = tgt;
        m_cnt = m_cnt + 1;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; npc_op = 2'd0; br_cond = 1'b0;
    ext_off = 32'd0; instr_index = 26'd0; rs_val = 32'd0;
    @(posedge clk); #1;
    m_pc = RESET_PC; m_cnt = 0; m_err = 0; m_halt = 0;

    // Sequential run from reset.
    step(0, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 1, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    // Reach 0x3010 via jr, then branch taken / not taken.
    step(0, 0, 2'd3, 0, 0, 0, 32'h0000_3010);
    step(0, 0, 2'd1, 1, 32'hFFFF_FFF8, 0, 0);
    step(0, 0, 2'd3, 0, 0, 0, 32'h0000_3010);
    step(0, 0, 2'd1, 0, 32'hFFFF_FFF8, 0, 0);
    // Jump from reset PC.
    step(1, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd2, 1, 0, 26'h0000C10, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    // Misaligned jr traps; HALT ignores further selects; reset recovers.
    step(0, 0, 2'd3, 0, 0, 0, 32'h0000_3022);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd2, 0, 0, 26'h1234, 0);
    step(0, 1, 2'd3, 0, 0, 0, 32'h4000);
    step(1, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    // Stall with a pending misaligned jr, then reset under stall.
    step(0, 1, 2'd3, 0, 0, 0, 32'h0000_3001);
    step(0, 1, 2'd3, 0, 0, 0, 32'h0000_3001);
    step(1, 1, 2'd3, 0, 0, 0, 32'h0000_3001);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    // Wrap at the top of the address space.
    step(0, 0, 2'd3, 0, 0, 0, 32'hFFFF_FFFC);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0);

    // Randomized traffic with occasional resets, stalls and misaligned jr.
    for (int i = 0; i < 600; i++) begin
      logic        r_rst;
      logic        r_stl;
      logic [1:0]  r_op;
      logic [31:0] r_rs;
      logic [31:0] r_off;
      r_rst = ($urandom_range(0, 29) == 0);
      r_stl = ($urandom_range(0, 4) == 0);
      r_op  = 2'($urandom_range(0, 3));
      r_rs  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) r_rs[1:0] = 2'($urandom_range(1, 3));
      r_off = {{14{1'b0}}, 18'($urandom)} << 2;
      if ($urandom_range(0, 1) == 1) r_off = -r_off;
      step(r_rst, r_stl, r_op, 1'($urandom), r_off, 26'($urandom), r_rs);
    end

    // Bounded drain of outstanding expectations.
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(posedge clk);
    cmp("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
